phase_bank: RTL

- Parametrised multi-channel phase register bank for the transducer array.
- Accepts 32-bit command words over a valid/ready handshake and holds a shadow and an active phase per channel.
- Keeps a per-channel calibration offset and drives calibration-corrected phases plus PWM enables to the per-channel PWM generators.
- Supports atomic array-wide commit (command or external sync strobe) and a multi-cycle clear sweep.

---
 rtl/phase_bank_pkg.sv | 32 +++
 rtl/phase_bank_channel.sv | 71 +++++++
 rtl/phase_bank.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/phase_bank_pkg.sv
// Shared definitions for the transducer phase bank: command field layout,
// opcodes, controller states and the broadcast channel code.
// Imported by the top level and the per-channel register slice.
package phase_bank_pkg;

  typedef enum logic [2:0] {
    OP_WRITE_SHADOW  = 3'd0,
    OP_WRITE_DIRECT  = 3'd1,
    OP_COMMIT        = 3'd2,
    OP_CALIB_CAPTURE = 3'd3,
    OP_CLEAR_ALL     = 3'd4
  } opcode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam int CH_LSB = 8;
  localparam int CH_W   = 8;
  localparam int EN_BIT = 16;
  localparam int OP_LSB = 17;
  localparam int OP_W   = 3;

  localparam logic [CH_W-1:0] CH_BROADCAST = 8'hFF;

  // Opcodes 5..7 carry no meaning and are rejected.
  function automatic logic is_reserved(input logic [OP_W-1:0] op);
    return op > 3'd4;
  endfunction

endpackage

// File: rtl/phase_bank_channel.sv
// One transducer channel: shadow/active phase and enable plus calibration offset.
// Corrected phase is combinational from the registers (no added latency).
// No backpressure; strobes from the controller are applied on the next edge.
module phase_bank_channel #(
  parameter int PHASE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_shadow,
  input  logic               wr_direct,
  input  logic               commit,
  input  logic               capture,
  input  logic               clear,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic               en_in,
  output logic [PHASE_W-1:0] phase_out,
  output logic               pwm_en
);

  logic [PHASE_W-1:0] shadow_phase;
  logic [PHASE_W-1:0] active_phase;
  logic [PHASE_W-1:0] calib;
  logic               shadow_en;
  logic               active_en;

  // Shadow takes any write; the sweep clear overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_phase <= '0;
      shadow_en    <= 1'b0;
    end else if (clear) begin
      shadow_phase <= '0;
      shadow_en    <= 1'b0;
    end else if (wr_shadow || wr_direct) begin
      shadow_phase <= phase_in;
      shadow_en    <= en_in;
    end
  end

  // A direct write beats a same-edge commit; a commit copies the pre-write shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_phase <= '0;
      active_en    <= 1'b0;
    end else if (clear) begin
      active_phase <= '0;
      active_en    <= 1'b0;
    end else if (wr_direct) begin
      active_phase <= phase_in;
      active_en    <= en_in;
    end else if (commit) begin
      active_phase <= shadow_phase;
      active_en    <= shadow_en;
    end
  end

  // Calibration snapshots the active phase as it stood before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calib <= '0;
    end else if (clear) begin
      calib <= '0;
    end else if (capture) begin
      calib <= active_phase;
    end
  end

  assign phase_out = active_phase - calib;
  assign pwm_en    = active_en;

endmodule

// File: rtl/phase_bank.sv
// Multi-channel phase register bank: command decode, array commit, clear sweep.
// Commands take effect on the accept edge; outputs are combinational from registers.
// cmd_ready drops for the NUM_CHANNELS-cycle clear sweep; otherwise always ready.
module phase_bank
  import phase_bank_pkg::*;
#(
  parameter int NUM_CHANNELS = 64,
  parameter int PHASE_W      = 8,
  parameter int CH_BASE      = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [31:0]                     cmd_data,
  input  logic                            sync_commit,
  output logic [NUM_CHANNELS*PHASE_W-1:0] phase_out,
  output logic [NUM_CHANNELS-1:0]         pwm_en,
  output logic                            busy,
  output logic                            cmd_err
);

  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CHANNELS - 1);

  state_t             state_q, state_d;
  logic [CH_W-1:0]    idx_q, idx_d;
  logic               pending_q;

  opcode_t            op;
  logic [CH_W-1:0]    ch;
  logic [CH_W-1:0]    lch_idx;
  int                 lch;
  logic               ch_ok;
  logic               is_bcast;
  logic               accept;
  logic               wr_shadow_cmd;
  logic               wr_direct_cmd;
  logic               cap_cmd;
  logic               clear_cmd;
  logic               commit_all;
  logic               err_now;
  logic               unused_bits;

  assign op        = opcode_t'(cmd_data[OP_LSB +: OP_W]);
  assign ch        = cmd_data[CH_LSB +: CH_W];
  assign is_bcast  = (ch == CH_BROADCAST);
  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q == SWEEP) || pending_q;

  // Map the board-level channel field onto a local index and range-check it.
  always_comb begin
    lch     = int'(ch) - CH_BASE;
    ch_ok   = (lch >= 0) && (lch < NUM_CHANNELS);
    lch_idx = lch[CH_W-1:0];
  end

  // Command decode into per-array strobes and the error flag.
  always_comb begin
    wr_shadow_cmd = accept && (op == OP_WRITE_SHADOW) && ch_ok;
    wr_direct_cmd = accept && (op == OP_WRITE_DIRECT) && ch_ok;
    cap_cmd       = accept && (op == OP_CALIB_CAPTURE) && (ch_ok || is_bcast);
    clear_cmd     = accept && (op == OP_CLEAR_ALL);
    // A commit deferred by the sweep fires on the first idle cycle, alongside
    // any command accepted in that cycle.
    commit_all    = (state_q == IDLE) &&
                    (sync_commit || pending_q || (accept && (op == OP_COMMIT)));
    err_now       = accept &&
                    (is_reserved(cmd_data[OP_LSB +: OP_W]) ||
                     (((op == OP_WRITE_SHADOW) || (op == OP_WRITE_DIRECT)) && !ch_ok) ||
                     ((op == OP_CALIB_CAPTURE) && !ch_ok && !is_bcast));
  end

  // Next-state logic: the sweep visits every channel once, then returns to idle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clear_cmd) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and sweep index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Remember a sync strobe seen mid-sweep; drop it once the commit is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
    end else if ((state_q == SWEEP) && sync_commit) begin
      pending_q <= 1'b1;
    end else if (commit_all) begin
      pending_q <= 1'b0;
    end
  end

  // Error pulse appears the cycle after the offending command is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= err_now;
    end
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic sel;
    assign sel = ch_ok && (lch_idx == CH_W'(i));

    phase_bank_channel #(
      .PHASE_W(PHASE_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_shadow (wr_shadow_cmd && sel),
      .wr_direct (wr_direct_cmd && sel),
      .commit    (commit_all),
      .capture   (cap_cmd && (is_bcast || sel)),
      .clear     ((state_q == SWEEP) && (idx_q == CH_W'(i))),
      .phase_in  (cmd_data[PHASE_W-1:0]),
      .en_in     (cmd_data[EN_BIT]),
      .phase_out (phase_out[i*PHASE_W +: PHASE_W]),
      .pwm_en    (pwm_en[i])
    );
  end

  assign unused_bits = ^{cmd_data[31:20], cmd_data[7:0], lch[31:CH_W]};

endmodule
